pwm_audio_out: RTL

Output end of the mixer path. Accepts 8-bit mixed samples with a valid strobe and double-buffers them. Converts the active sample into a single-bit PWM stream for the board low-pass filter or speaker.
Runs one PWM period per sample and requests the next sample at each period boundary.

---
 rtl/synth_pkg.sv | 18 +
 rtl/pwm_prescaler.sv | 49 ++++
 rtl/pwm_audio_out.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the audio output path.
//   SAMPLE_W_DEF : default sample / PWM counter width
//   pwm_state_e  : block state (IDLE, RUN, RAMP). RAMP is reachable only
//                  when the soft-start feature (PWM_SOFT_START_EN) is built in.
// ---------------------------------------------------------------------------
package synth_pkg;

    localparam int SAMPLE_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RAMP = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_prescaler.sv
// ---------------------------------------------------------------------------
// pwm_prescaler
// Divides the system clock down to the PWM tick rate.
//   clk    : system clock
//   nRst   : asynchronous active-low reset
//   run_i  : count while high; counter is held at 0 while low
//   tick_o : high for one cycle out of every CLK_DIV while running
//            (every cycle when CLK_DIV = 1)
// CLK_DIV legal range is 1..256.
// ---------------------------------------------------------------------------
module pwm_prescaler #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic nRst,
    input  logic run_i,
    output logic tick_o
);

    // A 1-bit counter is kept even for CLK_DIV = 1 so the logic stays uniform;
    // it simply never leaves 0 in that case.
    localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (!run_i) begin
            div_d = '0;
        end else if (div_q == LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = run_i && (div_q == LAST);

endmodule

// File: rtl/pwm_audio_out.sv
// ---------------------------------------------------------------------------
// pwm_audio_out
// Output end of the mixer path: double-buffers 8-bit mixed samples and turns
// the active sample into a single-bit PWM stream, one PWM period per sample.
//   clk          : system clock
//   nRst         : asynchronous active-low reset
//   en           : block enable; low returns the block to IDLE
//   mixed_sample : sample from the mixer
//   sample_valid : one-cycle strobe qualifying mixed_sample
//   sample_req   : one-cycle pulse on each PWM period wrap
//   pwm_out      : registered PWM output (one cycle behind the counter)
//   underrun     : pulse, wrap happened with the shadow buffer empty
//   overrun      : pulse, a sample arrived while the shadow buffer was full
// Optional feature macro: PWM_SOFT_START_EN. When defined, leaving IDLE goes
// through RAMP, where the duty climbs by one step per wrap up to the buffered
// sample to avoid a power-on pop. Without it the block goes IDLE -> RUN.
// ---------------------------------------------------------------------------
module pwm_audio_out
    import synth_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int CLK_DIV  = 1
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] mixed_sample,
    input  logic                sample_valid,
    output logic                sample_req,
    output logic                pwm_out,
    output logic                underrun,
    output logic                overrun
);

`ifdef PWM_SOFT_START_EN
    localparam pwm_state_e START_STATE = RAMP;
`else
    localparam pwm_state_e START_STATE = RUN;
`endif

    pwm_state_e          state_q, state_d;
    logic [SAMPLE_W-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] shadow_q, shadow_d;
    logic                shadow_full_q, shadow_full_d;
    logic [SAMPLE_W-1:0] active_q, active_d;
    logic                pwm_q, pwm_d;

    logic running;
    logic tick;
    logic wrap;
    logic underrun_c;
    logic overrun_c;

    // The prescaler only counts once the block has left IDLE, so the first
    // RUN cycle always starts at prescaler 0 / counter 0.
    assign running = en && (state_q != IDLE);

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .nRst   (nRst),
        .run_i  (running),
        .tick_o (tick)
    );

    assign wrap = tick && (cnt_q == '1);

`ifdef PWM_SOFT_START_EN
    logic [SAMPLE_W-1:0] ramp_target;
    // shadow_full is left alone during RAMP, so it tells us whether any
    // sample has been buffered yet; with none the target is 0.
    assign ramp_target = shadow_full_q ? shadow_q : '0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        active_d      = active_q;
        pwm_d         = 1'b0;
        underrun_c    = 1'b0;
        overrun_c     = 1'b0;

        if (!en) begin
            state_d       = IDLE;
            cnt_d         = '0;
            shadow_full_d = 1'b0;
            active_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = START_STATE;
                end

                RUN: begin
                    if (tick) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    pwm_d = (cnt_q < active_q);
                    if (wrap) begin
                        if (shadow_full_q) begin
                            active_d      = shadow_q;
                            shadow_full_d = 1'b0;
                        end else begin
                            underrun_c = 1'b1;
                        end
                    end
                    // A load coincident with a wrap lands after the transfer,
                    // so the slot it fills has just been emptied: no overrun.
                    if (sample_valid) begin
                        overrun_c     = shadow_full_q && !wrap;
                        shadow_d      = mixed_sample;
                        shadow_full_d = 1'b1;
                    end
                end

`ifdef PWM_SOFT_START_EN
                RAMP: begin
                    if (tick) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    pwm_d = (cnt_q < active_q);
                    if (active_q >= ramp_target) begin
                        state_d = RUN;
                    end else if (wrap) begin
                        active_d = active_q + 1'b1;
                    end
                    if (sample_valid) begin
                        overrun_c     = shadow_full_q;
                        shadow_d      = mixed_sample;
                        shadow_full_d = 1'b1;
                    end
                end
`endif

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            active_q      <= '0;
            pwm_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            active_q      <= active_d;
            pwm_q         <= pwm_d;
        end
    end

    assign sample_req = wrap;
    assign underrun   = underrun_c;
    assign overrun    = overrun_c;
    assign pwm_out    = pwm_q;

endmodule
